// File: rtl/pkt_bus_arbiter.sv
// pkt_bus_arbiter: round-robin arbiter driving one registered packet slot.
// Requester words are split into addr = word[15:8] and data = word[7:0].
// A stall watchdog drops a held packet after TIMEOUT_CYC stalled cycles.
// Setting TIMEOUT_CYC to 0 turns the watchdog off.
// Optional feature: define PKT_ARB_GRANT_CNT_EN to add per-requester 16-bit capture counters.
module pkt_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*16-1:0]      req_word,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_addr,
  output logic [7:0]                 out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       err_timeout
`ifdef PKT_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_cnt
`endif
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             err_q, err_d;
  logic [31:0]      stall_q, stall_d;

  logic             grant_found_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [15:0]      grant_word_s;
  logic             drop_s;
  logic             cap_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx_v;
      idx_v = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found_s && req_valid[idx_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = SRC_W'(idx_v);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign grant_word_s = req_word[{grant_idx_s, 4'b0000} +: 16];

  // Watchdog drop fires on the last allowed stalled cycle; capture is blocked that cycle.
  always_comb begin
    drop_s = 1'b0;
    cap_s  = 1'b0;
    if ((TIMEOUT_CYC > 0) && (state_q == ST_HOLD) && !out_ready &&
        (stall_q == 32'(TIMEOUT_CYC - 1))) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
    if (!rst && grant_found_s && !drop_s &&
        ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready))) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
  end

  // One-hot ready to the granted requester in the capture cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = cap_s && (grant_idx_s == SRC_W'(i));
    end
  end

  // Next-state logic for the packet slot, round-robin pointer and stall counter.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    src_d    = src_q;
    err_d    = drop_s;
    stall_d  = stall_q;
    case (state_q)
      ST_IDLE: begin
        stall_d = 32'd0;
        if (cap_s) begin
          state_d  = ST_HOLD;
          rr_ptr_d = grant_idx_s;
          addr_d   = grant_word_s[15:8];
          data_d   = grant_word_s[7:0];
          src_d    = grant_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (drop_s) begin
          state_d = ST_IDLE;
          stall_d = 32'd0;
        end else if (cap_s) begin
          state_d  = ST_HOLD;
          rr_ptr_d = grant_idx_s;
          addr_d   = grant_word_s[15:8];
          data_d   = grant_word_s[7:0];
          src_d    = grant_idx_s;
          stall_d  = 32'd0;
        end else if (out_ready) begin
          state_d = ST_IDLE;
          stall_d = 32'd0;
        end else begin
          stall_d = stall_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 32'd0;
      end
    endcase
  end

  // State and packet registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= SRC_W'(NUM_REQ - 1);
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      src_q    <= '0;
      err_q    <= 1'b0;
      stall_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      src_q    <= src_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign out_addr    = addr_q;
  assign out_data    = data_q;
  assign out_src     = src_q;
  assign err_timeout = err_q;

`ifdef PKT_ARB_GRANT_CNT_EN
  logic [15:0] gcnt_q [NUM_REQ];

  // Per-requester wrapping capture counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= 16'h0000;
      end
    end else if (cap_s) begin
      gcnt_q[grant_idx_s] <= gcnt_q[grant_idx_s] + 16'h0001;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[16*g +: 16] = gcnt_q[g];
  end
`endif

endmodule
